sar_search_8bit: RTL and testbench

SAR_SEARCH_8BIT -- requirements
Module: sar_search_8bit

---
 rtl/sar_search_8bit.sv | 160 ++++++++++++++++
 tb/tb_sar_search_8bit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_8bit.sv
// ---------------------------------------------------------------------------
// SarSearch8bit (module sar_search_8bit)
//
// Purpose:
//   This block is the control half of an 8-bit successive-approximation search.
//   It drives a trial operand on 'guess' to an external magnitude comparator.
//   The comparator has the unknown target on its other input. The block reads
//   the greater/less/equal flags back, one bit decision per clock. After eight
//   evaluations, 'guess' has converged on the target.
//
// Ports:
//   clk      in   1  rising-edge clock for all state
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  request a new search (accepted only while idle)
//   greater  in   1  comparator flag: guess > target
//   less     in   1  comparator flag: guess < target
//   equal    in   1  comparator flag: guess == target
//   guess    out  8  registered trial operand (comparator input a)
//   busy     out  1  high while a search is in progress
//   done     out  1  one-cycle pulse: search finished successfully
//   result   out  8  converged value, held until the next done
//   error    out  1  one-cycle pulse: search aborted on illegal flags
//   steps    out  4  evaluation count of the last completed/aborted search
//
// Configuration:
//   SAR_EARLY_EXIT_EN - when defined, a legal evaluation that reports equal
//                       finishes the search immediately. When undefined,
//                       equal is treated as "keep the bit", and every search
//                       runs the full eight evaluations.
// ---------------------------------------------------------------------------
module sar_search_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       greater,
    input  logic       less,
    input  logic       equal,
    output logic [7:0] guess,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       error,
    output logic [3:0] steps
);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t     state, state_d;
    logic [7:0] guess_d, result_d, kept_guess;
    logic [2:0] bit_idx, bit_idx_d;
    logic [3:0] step_cnt, step_cnt_d, steps_d, evals;
    logic       busy_d, done_d, error_d, legal;

    // State register.
    // All outputs are registered, so every output comes straight from a flop.
    // done and error are pulses because their next values default to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            guess    <= 8'h00;
            bit_idx  <= 3'd0;
            step_cnt <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            result   <= 8'h00;
            steps    <= 4'd0;
        end else begin
            state    <= state_d;
            guess    <= guess_d;
            bit_idx  <= bit_idx_d;
            step_cnt <= step_cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            result   <= result_d;
            steps    <= steps_d;
        end
    end

    // Next-state logic.
    // Each clock spent in SEARCH is one evaluation of the flags for the
    // current guess. The flags are legal only when exactly one of them is
    // high. kept_guess is the current guess after the bit decision: the bit
    // under test is cleared when the guess overshoots the target.
    always_comb begin
        state_d    = state;
        guess_d    = guess;
        bit_idx_d  = bit_idx;
        step_cnt_d = step_cnt;
        busy_d     = busy;
        done_d     = 1'b0;
        error_d    = 1'b0;
        result_d   = result;
        steps_d    = steps;

        legal = ({greater, less, equal} == 3'b100) ||
                ({greater, less, equal} == 3'b010) ||
                ({greater, less, equal} == 3'b001);
        evals = step_cnt + 4'd1;

        kept_guess = guess;
        if (greater) begin
            kept_guess[bit_idx] = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    guess_d    = 8'h80;
                    bit_idx_d  = 3'd7;
                    busy_d     = 1'b1;
                    step_cnt_d = 4'd0;
                    state_d    = SEARCH;
                end
            end

            SEARCH: begin
                step_cnt_d = evals;
                if (!legal) begin
                    // Abort the search and leave guess and result untouched.
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    steps_d = evals;
                    state_d = IDLE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (equal) begin
                    result_d = guess;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    steps_d  = evals;
                    state_d  = IDLE;
                end
`endif
                else if (bit_idx == 3'd0) begin
                    guess_d  = kept_guess;
                    result_d = kept_guess;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    steps_d  = 4'd8;
                    state_d  = IDLE;
                end else begin
                    // Set the next lower bit as the next trial bit.
                    guess_d                  = kept_guess;
                    guess_d[bit_idx - 3'd1]  = 1'b1;
                    bit_idx_d                = bit_idx - 3'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search_8bit.sv
// ---------------------------------------------------------------------------
// tb_sar_search_8bit
//
// Purpose:
//   This is a self-checking bench for sar_search_8bit. A small comparator
//   model drives the flags from the DUT guess and a bench-held target. The
//   bench can force the flags illegal when it needs to. A table of targets
//   with hand-computed results, step counts and latencies is run in a loop.
//   Hand-written sequences cover the guess walk, illegal flags, ignored
//   start, reset mid-search and back-to-back searches.
//
// Configuration:
//   SAR_EARLY_EXIT_EN - must match the RTL build; it selects which step
//                       counts and latencies are expected.
// ---------------------------------------------------------------------------
module tb_sar_search_8bit;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       greater, less, equal;
    logic [7:0] guess, result;
    logic       busy, done, error;
    logic [3:0] steps;

    logic [7:0] target = 8'h00;
    logic       force_bad = 1'b0;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] target;
        logic [7:0] exp_result;
        int         steps_full;
        int         steps_early;
    } vec_t;

    vec_t vecs[11];

    sar_search_8bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .greater (greater),
        .less    (less),
        .equal   (equal),
        .guess   (guess),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .error   (error),
        .steps   (steps)
    );

    always #5 clk = ~clk;

    // Comparator model: greater and less together is the illegal pattern.
    assign greater = force_bad ? 1'b1 : (guess > target);
    assign less    = force_bad ? 1'b1 : (guess < target);
    assign equal   = force_bad ? 1'b0 : (guess == target);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sets up a search with the start edge, then counts evaluation edges
    // until done or error is seen, within a bounded number of edges.
    task automatic applyStimulus(input logic [7:0] tgt, output int edges);
        target = tgt;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("busy after start", busy, 1);
        checkOutput("guess after start", guess, 8'h80);
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 edges++;
            if (done || error) break;
        end
        if (!(done || error)) checkOutput("search timeout", 1, 0);
    endtask

    function automatic int expSteps(input int full, input int early);
        return EARLY ? early : full;
    endfunction

    initial begin
        int         edges;
        int         exp_n;
        logic [7:0] last_result;
        logic [7:0] seq[8];

        vecs[0]  = '{8'h00, 8'h00, 8, 8};
        vecs[1]  = '{8'hFF, 8'hFF, 8, 8};
        vecs[2]  = '{8'h80, 8'h80, 8, 1};
        vecs[3]  = '{8'h5A, 8'h5A, 8, 7};
        vecs[4]  = '{8'h3C, 8'h3C, 8, 6};
        vecs[5]  = '{8'hA5, 8'hA5, 8, 8};
        vecs[6]  = '{8'h0F, 8'h0F, 8, 8};
        vecs[7]  = '{8'h01, 8'h01, 8, 8};
        vecs[8]  = '{8'h7F, 8'h7F, 8, 8};
        vecs[9]  = '{8'h40, 8'h40, 8, 2};
        vecs[10] = '{8'hC3, 8'hC3, 8, 8};

        seq[0] = 8'h80; seq[1] = 8'h40; seq[2] = 8'h20; seq[3] = 8'h10;
        seq[4] = 8'h08; seq[5] = 8'h04; seq[6] = 8'h02; seq[7] = 8'h01;

        // Reset state
        #2;
        checkOutput("reset guess", guess, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset error", error, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset steps", steps, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Guess walk for target 00
        target = 8'h00;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("walk guess 0", guess, seq[0]);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1 checkOutput($sformatf("walk guess %0d", k), guess, seq[k]);
            checkOutput($sformatf("walk no done %0d", k), done, 0);
        end
        @(posedge clk);
        #1 checkOutput("walk done", done, 1);
        checkOutput("walk result", result, 8'h00);
        checkOutput("walk steps", steps, 8);

        // Table of targets
        for (int i = 0; i < 11; i++) begin
            exp_n = expSteps(vecs[i].steps_full, vecs[i].steps_early);
            applyStimulus(vecs[i].target, edges);
            checkOutput($sformatf("v%0d latency", i), edges, exp_n);
            checkOutput($sformatf("v%0d done", i), done, 1);
            checkOutput($sformatf("v%0d error", i), error, 0);
            checkOutput($sformatf("v%0d busy", i), busy, 0);
            checkOutput($sformatf("v%0d result", i), result, vecs[i].exp_result);
            checkOutput($sformatf("v%0d steps", i), steps, exp_n);
            @(posedge clk);
            #1 checkOutput($sformatf("v%0d done pulse", i), done, 0);
        end
        last_result = vecs[10].exp_result;

        // Flags ignored while idle
        force_bad = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkOutput("idle flags error", error, 0);
        checkOutput("idle flags busy", busy, 0);
        checkOutput("idle flags steps", steps, expSteps(8, 8));
        force_bad = 1'b0;

        // Illegal flags on the 3rd evaluation of target 5A
        target = 8'h5A;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 force_bad = 1'b1;
        @(posedge clk);
        #1 force_bad = 1'b0;
        checkOutput("err pulse", error, 1);
        checkOutput("err done", done, 0);
        checkOutput("err busy", busy, 0);
        checkOutput("err result", result, last_result);
        checkOutput("err guess", guess, 8'h60);
        checkOutput("err steps", steps, 3);
        @(posedge clk);
        #1 checkOutput("err pulse width", error, 0);
        checkOutput("err stays idle", busy, 0);

        // start during the 2nd evaluation of target 3C is ignored
        target = 8'h3C;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 2;
        for (int k = 0; k < 20; k++) begin
            if (done || error) break;
            @(posedge clk);
            #1 edges++;
        end
        checkOutput("restart latency", edges, expSteps(8, 6));
        checkOutput("restart done", done, 1);
        checkOutput("restart result", result, 8'h3C);
        checkOutput("restart steps", steps, expSteps(8, 6));

        // Reset during the 4th evaluation abandons the search
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("mid reset guess", guess, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset result", result, 0);
        checkOutput("mid reset steps", steps, 0);
        checkOutput("mid reset error", error, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 checkOutput($sformatf("held reset done %0d", k), done, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 checkOutput($sformatf("post reset done %0d", k), done, 0);
        end

        // Back-to-back searches: A5, then 0F started in the done cycle
        applyStimulus(8'hA5, edges);
        checkOutput("b2b first done", done, 1);
        checkOutput("b2b first result", result, 8'hA5);
        target = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("b2b accepted", busy, 1);
        checkOutput("b2b guess", guess, 8'h80);
        checkOutput("b2b no done", done, 0);
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 edges++;
            if (done || error) break;
        end
        checkOutput("b2b latency", edges, 8);
        checkOutput("b2b done", done, 1);
        checkOutput("b2b result", result, 8'h0F);
        checkOutput("b2b steps", steps, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
